// File: rtl/glitch_seq_pkg.sv
// Shared definitions for the glitch sequencer: FSM state codes, register map and bit positions.
// No logic here beyond a byte-strobe merge helper.
package glitch_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_PULSE = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_DELAY  = 3'd1;
   localparam logic [2:0] REG_WIDTH  = 3'd2;
   localparam logic [2:0] REG_GAP    = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   localparam int CTRL_ARM        = 0;
   localparam int CTRL_ABORT      = 1;
   localparam int CTRL_TRIG_RISE  = 2;
   localparam int CTRL_OUT_POL    = 3;
   localparam int CTRL_PULSES_LSB = 8;

   localparam int STAT_STATE_LSB  = 0;
   localparam int STAT_DONE       = 8;
   localparam int STAT_ABORTED    = 9;
   localparam int STAT_ISSUED_LSB = 16;

   typedef struct packed {
      logic [7:0] pulses;
      logic       out_pol;
      logic       trig_rise;
   } ctrl_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wdat,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (strb[b]) r[8*b +: 8] = wdat[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/glitch_trig_sync.sv
// Trigger synchronizer plus edge detector; trig_edge is high for one cycle, SYNC_STAGES cycles
// after the input changes. No backpressure: edges are simply reported.
module glitch_trig_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic trigger_in,
   input  logic rise,
   output logic trig_edge
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign trig_edge = rise ? (sync_q[SYNC_STAGES-1] & ~prev_q)
                           : (~sync_q[SYNC_STAGES-1] & prev_q);

endmodule

// File: rtl/glitch_sequencer.sv
// iomem-mapped power-dip glitch sequencer: trigger edge -> delay -> train of pulses on glitch_out.
// Bus acks one cycle after request, never stalls; trigger-to-glitch is SYNC_STAGES+2+DELAY cycles.
module glitch_sequencer
   import glitch_seq_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR   = 8'h05,
   parameter int         SYNC_STAGES = 2,
   parameter int         DELAY_W     = 32,
   parameter int         WIDTH_W     = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   input  logic        trigger_in,
   output logic        glitch_out,
   output logic        busy,
   output logic        done_irq
);

   state_t               state, state_nxt;
   ctrl_t                ctrl_r;
   logic [DELAY_W-1:0]   delay_r, cnt, cnt_nxt, width_m1, gap_m1;
   logic [WIDTH_W-1:0]   width_r, gap_r;
   logic [7:0]           issued, issued_nxt, pulses_eff;
   logic                 done_r, done_nxt, aborted_r, aborted_nxt, glitch_nxt;
   logic                 sel, wr, arm_wr, abort_wr, trig_edge;
   logic [2:0]           reg_sel;
   logic [31:0]          rd_mux;
   logic                 unused_addr;

   assign sel      = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
   assign wr       = sel && (iomem_wstrb != 4'b0000);
   assign reg_sel  = iomem_addr[4:2];
   assign arm_wr   = wr && (reg_sel == REG_CTRL) && iomem_wstrb[0] && iomem_wdata[CTRL_ARM];
   assign abort_wr = wr && (reg_sel == REG_CTRL) && iomem_wstrb[0] && iomem_wdata[CTRL_ABORT];
   assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

   // Zero-valued width/gap/pulse settings behave as 1.
   assign pulses_eff = (ctrl_r.pulses == 8'd0) ? 8'd1 : ctrl_r.pulses;
   assign width_m1   = (width_r == '0) ? '0 : DELAY_W'(width_r - WIDTH_W'(1));
   assign gap_m1     = (gap_r == '0) ? '0 : DELAY_W'(gap_r - WIDTH_W'(1));

   glitch_trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig (
      .clk        (clk),
      .resetn     (resetn),
      .trigger_in (trigger_in),
      .rise       (ctrl_r.trig_rise),
      .trig_edge  (trig_edge)
   );

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_CTRL: begin
            rd_mux[CTRL_TRIG_RISE]         = ctrl_r.trig_rise;
            rd_mux[CTRL_OUT_POL]           = ctrl_r.out_pol;
            rd_mux[CTRL_PULSES_LSB +: 8]   = ctrl_r.pulses;
         end
         REG_DELAY:  rd_mux = 32'(delay_r);
         REG_WIDTH:  rd_mux = 32'(width_r);
         REG_GAP:    rd_mux = 32'(gap_r);
         REG_STATUS: begin
            rd_mux[STAT_STATE_LSB +: 3]    = state;
            rd_mux[STAT_DONE]              = done_r;
            rd_mux[STAT_ABORTED]           = aborted_r;
            rd_mux[STAT_ISSUED_LSB +: 8]   = issued;
         end
         default: rd_mux = '0;
      endcase
   end

   // Configuration is frozen while a sequence is in flight.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         ctrl_r      <= '0;
         delay_r     <= '0;
         width_r     <= '0;
         gap_r       <= '0;
      end else begin
         iomem_ready <= sel;
         if (sel) iomem_rdata <= rd_mux;
         if (wr && state == ST_IDLE) begin
            case (reg_sel)
               REG_CTRL: begin
                  if (iomem_wstrb[0]) begin
                     ctrl_r.trig_rise <= iomem_wdata[CTRL_TRIG_RISE];
                     ctrl_r.out_pol   <= iomem_wdata[CTRL_OUT_POL];
                  end
                  if (iomem_wstrb[1]) ctrl_r.pulses <= iomem_wdata[CTRL_PULSES_LSB +: 8];
               end
               REG_DELAY: delay_r <= DELAY_W'(apply_strb(32'(delay_r), iomem_wdata, iomem_wstrb));
               REG_WIDTH: width_r <= WIDTH_W'(apply_strb(32'(width_r), iomem_wdata, iomem_wstrb));
               REG_GAP:   gap_r   <= WIDTH_W'(apply_strb(32'(gap_r), iomem_wdata, iomem_wstrb));
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         issued     <= '0;
         done_r     <= 1'b0;
         aborted_r  <= 1'b0;
         glitch_out <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         issued     <= issued_nxt;
         done_r     <= done_nxt;
         aborted_r  <= aborted_nxt;
         glitch_out <= glitch_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      issued_nxt  = issued;
      done_nxt    = done_r;
      aborted_nxt = aborted_r;
      case (state)
         ST_IDLE: begin
            if (arm_wr && !abort_wr) begin
               state_nxt   = ST_ARMED;
               done_nxt    = 1'b0;
               aborted_nxt = 1'b0;
               issued_nxt  = '0;
            end
         end
         ST_ARMED: begin
            if (trig_edge) begin
               state_nxt = ST_DELAY;
               cnt_nxt   = delay_r;
            end
         end
         ST_DELAY: begin
            if (cnt == '0) begin
               state_nxt = ST_PULSE;
               cnt_nxt   = width_m1;
            end else begin
               cnt_nxt = cnt - DELAY_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               issued_nxt = issued + 8'd1;
               if ((issued + 8'd1) == pulses_eff) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_GAP;
                  cnt_nxt   = gap_m1;
               end
            end else begin
               cnt_nxt = cnt - DELAY_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               state_nxt = ST_PULSE;
               cnt_nxt   = width_m1;
            end else begin
               cnt_nxt = cnt - DELAY_W'(1);
            end
         end
         ST_DONE: begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort_wr && state != ST_IDLE) begin
         state_nxt   = ST_IDLE;
         aborted_nxt = 1'b1;
      end
   end

   // Registered drive; an abort returns the pin to idle on the very edge that accepts the write.
   assign glitch_nxt = (state == ST_PULSE && !abort_wr) ? ~ctrl_r.out_pol : ctrl_r.out_pol;
   assign busy       = (state != ST_IDLE);
   assign done_irq   = (state == ST_DONE);

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomized scoreboard bench for glitch_sequencer: expected bus responses and glitch pulses are
// queued at stimulus time and popped by independent monitors as the DUT produces them.
module tb_glitch_sequencer;

   localparam int          SYNC = 2;
   localparam logic [31:0] BASE = 32'h0500_0000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        trigger_in = 1'b0;
   logic        glitch_out, busy, done_irq;

   glitch_sequencer dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .trigger_in  (trigger_in),
      .glitch_out  (glitch_out),
      .busy        (busy),
      .done_irq    (done_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [31:0] dat; logic [31:0] mask; int due; } bus_exp_t;
   typedef struct { int start; int len; } pulse_t;
   bus_exp_t bus_q[$];
   pulse_t   pulse_q[$];

   logic mon_en = 1'b0;
   logic cur_pol = 1'b0;
   int   done_cnt = 0;
   int   exp_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // Bus response monitor.
   always @(negedge clk) begin
      bus_exp_t e;
      if (iomem_ready) begin
         if (bus_q.size() == 0) begin
            fail_event("bus_ready", "ready with no outstanding request");
         end else begin
            e = bus_q.pop_front();
            check("bus_ready_cycle", cyc, e.due);
            if (e.mask != 32'h0) check("bus_rdata", iomem_rdata & e.mask, e.dat & e.mask);
         end
      end
   end

   // Glitch pulse monitor: measures each active run against the expected pulse list.
   logic in_run = 1'b0;
   int   run_start = 0;
   always @(negedge clk) begin
      pulse_t p;
      if (done_irq) done_cnt++;
      if (!mon_en) begin
         in_run = 1'b0;
      end else if ((glitch_out ^ cur_pol) && !in_run) begin
         in_run = 1'b1;
         run_start = cyc;
      end else if (!(glitch_out ^ cur_pol) && in_run) begin
         in_run = 1'b0;
         if (pulse_q.size() == 0) begin
            fail_event("glitch_pulse", "unexpected glitch pulse");
         end else begin
            p = pulse_q.pop_front();
            check("pulse_start", run_start, p.start);
            check("pulse_len", cyc - run_start, p.len);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] wdat,
                      input logic [31:0] exp, input logic [31:0] mask);
      bus_exp_t e;
      e.dat = exp;
      e.mask = mask;
      e.due = cyc + 1;
      bus_q.push_back(e);
      iomem_valid = 1'b1;
      iomem_addr  = BASE | {27'h0, off, 2'b00};
      iomem_wstrb = strb;
      iomem_wdata = wdat;
      tick(1);
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      tick(1);
   endtask

   task automatic bus_wr(input logic [2:0] off, input logic [31:0] dat);
      bus(off, 4'hf, dat, 32'h0, 32'h0);
   endtask

   task automatic bus_rd(input logic [2:0] off, input logic [31:0] exp);
      bus(off, 4'h0, 32'h0, exp, 32'hffff_ffff);
   endtask

   function automatic logic [31:0] ctrl_word(input logic arm, input logic abort, input logic rise,
                                             input logic pol, input logic [7:0] pulses);
      return {16'h0, pulses, 4'h0, pol, rise, abort, arm};
   endfunction

   function automatic logic [31:0] status_word(input logic [2:0] st, input logic done,
                                               input logic aborted, input logic [7:0] issued);
      return {8'h0, issued, 6'h0, aborted, done, 5'h0, st};
   endfunction

   // Reference timing: first active cycle is SYNC+2+DELAY after the first sampling edge,
   // each pulse lasts max(WIDTH,1), separated by max(GAP,1), max(PULSES,1) of them.
   function automatic void push_train(input int t, input int delay, input int width,
                                      input int gap, input int pulses);
      pulse_t p;
      int w = (width == 0) ? 1 : width;
      int g = (gap == 0) ? 1 : gap;
      int n = (pulses == 0) ? 1 : pulses;
      int s = t + 1 + SYNC + 2 + delay;
      for (int i = 0; i < n; i++) begin
         p.start = s;
         p.len = w;
         pulse_q.push_back(p);
         s += w + g;
      end
   endfunction

   task automatic setup(input int delay, input int width, input int gap, input int pulses,
                        input logic pol, input logic rise, input logic trig0);
      mon_en = 1'b0;
      trigger_in = trig0;
      bus_wr(3'd1, delay);
      bus_wr(3'd2, width);
      bus_wr(3'd3, gap);
      bus_wr(3'd0, ctrl_word(1'b0, 1'b0, rise, pol, 8'(pulses)));
      cur_pol = pol;
      tick(4);
      mon_en = 1'b1;
      bus_wr(3'd0, ctrl_word(1'b1, 1'b0, rise, pol, 8'(pulses)));
      tick(2);
   endtask

   task automatic fire(input int delay, input int width, input int gap, input int pulses);
      trigger_in = ~trigger_in;
      push_train(cyc, delay, width, gap, pulses);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (pulse_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (pulse_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d pulses still pending after %0d cycles, expected 0",
                  pulse_q.size(), budget);
         pulse_q.delete();
      end
      tick(3);
   endtask

   task automatic run_seq(input int delay, input int width, input int gap, input int pulses,
                          input logic pol, input logic rise);
      setup(delay, width, gap, pulses, pol, rise, ~rise);
      fire(delay, width, gap, pulses);
      drain(600);
      exp_done++;
      check("done_irq_count", done_cnt, exp_done);
      bus_rd(3'd4, status_word(3'd0, 1'b1, 1'b0, (pulses == 0) ? 8'd1 : 8'(pulses)));
   endtask

   initial begin
      int s;
      tick(3);
      check("reset_glitch_out", {31'h0, glitch_out}, 32'h0);
      check("reset_ready", {31'h0, iomem_ready}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      resetn = 1'b1;
      tick(1);
      bus_rd(3'd4, 32'h0);
      bus_rd(3'd7, 32'h0);

      // Byte strobes merge per byte; unmapped offset ignores writes.
      bus_wr(3'd1, 32'h0);
      bus(3'd1, 4'b0010, 32'hffff_ffff, 32'h0, 32'h0);
      bus_rd(3'd1, 32'h0000_ff00);
      bus_wr(3'd6, 32'hdead_beef);
      bus_rd(3'd6, 32'h0);

      run_seq(10, 3, 0, 1, 1'b0, 1'b1);
      run_seq(0, 2, 5, 3, 1'b1, 1'b1);
      run_seq(0, 0, 0, 0, 1'b0, 1'b1);

      // Falling-edge mode: a rising edge must not fire.
      setup(3, 2, 0, 1, 1'b0, 1'b0, 1'b0);
      trigger_in = 1'b1;
      tick(8);
      bus_rd(3'd4, status_word(3'd1, 1'b0, 1'b0, 8'd0));
      fire(3, 2, 0, 1);
      drain(200);
      exp_done++;
      check("fall_done_count", done_cnt, exp_done);

      // Retrigger during DELAY is ignored.
      setup(30, 2, 0, 1, 1'b0, 1'b1, 1'b0);
      fire(30, 2, 0, 1);
      tick(6);
      trigger_in = 1'b0;
      tick(4);
      trigger_in = 1'b1;
      drain(200);
      exp_done++;
      check("retrig_done_count", done_cnt, exp_done);

      // DELAY write while ARMED is dropped.
      setup(5, 1, 0, 1, 1'b0, 1'b1, 1'b0);
      bus_wr(3'd1, 32'd100);
      bus_rd(3'd1, 32'd5);
      fire(5, 1, 0, 1);
      drain(200);
      exp_done++;
      check("armed_wr_done_count", done_cnt, exp_done);

      // ABORT mid-pulse: pin idles on the accepting edge, no done_irq.
      setup(0, 20, 0, 1, 1'b0, 1'b1, 1'b0);
      trigger_in = 1'b1;
      s = cyc + 1 + SYNC + 2;
      begin
         pulse_t p;
         p.start = s;
         p.len = 5;
         pulse_q.push_back(p);
      end
      while (cyc < s + 4) tick(1);
      bus_wr(3'd0, ctrl_word(1'b0, 1'b1, 1'b1, 1'b0, 8'd1));
      drain(50);
      tick(5);
      check("abort_no_done", done_cnt, exp_done);
      bus_rd(3'd4, status_word(3'd0, 1'b0, 1'b1, 8'd0));

      // ARM and ABORT together stays IDLE.
      bus_wr(3'd0, ctrl_word(1'b1, 1'b1, 1'b1, 1'b0, 8'd1));
      check("arm_abort_busy", {31'h0, busy}, 32'h0);
      bus(3'd4, 4'h0, 32'h0, 32'h0, 32'h7);

      // Reset in the middle of a gap with OUT_POL=1.
      setup(0, 2, 40, 3, 1'b1, 1'b1, 1'b0);
      trigger_in = 1'b1;
      s = cyc + 1 + SYNC + 2;
      begin
         pulse_t p;
         p.start = s;
         p.len = 2;
         pulse_q.push_back(p);
      end
      while (cyc < s + 6) tick(1);
      check("pre_reset_pulse_seen", pulse_q.size(), 32'd0);
      check("gap_busy", {31'h0, busy}, 32'h1);
      mon_en = 1'b0;
      pulse_q.delete();
      resetn = 1'b0;
      tick(1);
      check("rst_glitch_out", {31'h0, glitch_out}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done_irq", {31'h0, done_irq}, 32'h0);
      check("rst_ready", {31'h0, iomem_ready}, 32'h0);
      check("rst_rdata", iomem_rdata, 32'h0);
      resetn = 1'b1;
      cur_pol = 1'b0;
      trigger_in = 1'b0;
      tick(2);
      for (int r = 0; r < 5; r++) bus_rd(3'(r), 32'h0);

      for (int i = 0; i < 6; i++) begin
         run_seq(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      tick(3);
      check("bus_q_empty", bus_q.size(), 32'd0);
      check("pulse_q_empty", pulse_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Memory-mapped controller that sequences the power-dip glitch output of the SoC. Firmware arms it over the iomem peripheral bus. It then waits for an edge on the target trigger input, counts a programmable delay, and emits a programmable train of glitch pulses on the powerdip pin. It sits on the iomem bus beside the GPIO peripheral and runs entirely in the clk domain.

Parameters:
BASE_ADDR, 8'h05, iomem_addr[31:24] decode value
SYNC_STAGES, 2, flip-flops in the trigger synchronizer (minimum 2)
DELAY_W, 32, width of the delay counter/register
WIDTH_W, 16, width of the pulse-width and gap counters/registers

Ports:
clk  in  1  system clock
resetn  in  1  reset: synchronous, active-low; clock clk
iomem_valid  in  1  bus request
iomem_ready  out  1  bus acknowledge, one-cycle pulse
iomem_wstrb  in  4  byte write strobes; 0 means read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1
trigger_in  in  1  asynchronous target trigger
glitch_out  out  1  power-dip drive
busy  out  1  high in any state other than IDLE
done_irq  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset values: all registers 0, state IDLE, glitch_out=0, busy=0, done_irq=0, iomem_ready=0, iomem_rdata=0.
- Bus decode: select when iomem_valid && !iomem_ready && addr[31:24]==BASE_ADDR.
  - iomem_ready is high exactly one cycle later; rdata is updated in that same cycle.
  - Byte strobes apply per byte.
  - addr[4:2] selects the register. Unmapped offsets read 0 and ignore writes.
- Register 0, CTRL:
  - bit0 ARM: write-1, self-clearing, reads 0.
  - bit1 ABORT: write-1, self-clearing, reads 0.
  - bit2 TRIG_RISE: 1 = rising edge, 0 = falling edge.
  - bit3 OUT_POL: 1 = glitch_out idles high and pulses low.
  - [15:8] PULSES: pulse count; 0 is treated as 1.
- Register 1, DELAY[DELAY_W-1:0]. Register 2, WIDTH[WIDTH_W-1:0]. Register 3, GAP[WIDTH_W-1:0].
- Register 4, STATUS (read-only):
  - [2:0] state code.
  - bit8 DONE: sticky; cleared by ARM.
  - bit9 ABORTED: sticky; cleared by ARM.
  - [23:16] pulses issued.
- Writes to CTRL config bits, DELAY, WIDTH and GAP are ignored unless the state is IDLE. ABORT is always honoured.
- Trigger path: SYNC_STAGES-flop synchronizer, then a 1-flop edge detector producing trig_edge.
- FSM:
  - IDLE: ARM=1 -> ARMED. Clear DONE/ABORTED and the pulse counter.
  - ARMED: trig_edge -> DELAY, loading cnt=DELAY. An edge already in the pipe during the ARM write cycle is ignored.
  - DELAY: cnt==0 -> PULSE, loading cnt=max(WIDTH,1)-1. Otherwise cnt decrements.
  - PULSE: glitch_out=~OUT_POL. At cnt==0, increment pulses issued.
    - If issued==max(PULSES,1): -> DONE.
    - Otherwise -> GAP, loading cnt=max(GAP,1)-1.
  - GAP: cnt==0 -> PULSE, reloading the width.
  - DONE: set DONE sticky, pulse done_irq, -> IDLE next cycle.
- In every state except PULSE, glitch_out=OUT_POL.
- Latency: the first clk edge sampling the trigger at its new level to glitch_out active is exactly SYNC_STAGES+2+DELAY cycles.
- Pulse timing: active exactly max(WIDTH,1) cycles; inactive between pulses exactly max(GAP,1) cycles.
- Trigger edges in DELAY, PULSE, GAP or DONE are ignored; there is no retrigger.
- ABORT in any non-IDLE state: glitch_out returns to OUT_POL next cycle, ABORTED is set, -> IDLE, no done_irq.
- ARM and ABORT written together: ABORT wins and the state stays IDLE.
- ARM while not IDLE: ignored.
- resetn low mid-pulse: glitch_out=0 at the next clk edge, regardless of OUT_POL.
- STATUS state codes: IDLE 0, ARMED 1, DELAY 2, PULSE 3, GAP 4, DONE 5.

Decomposition:
- Package glitch_seq_pkg holds:
  - state enum codes.
  - register offsets: CTRL 0, DELAY 1, WIDTH 2, GAP 3, STATUS 4.
  - CTRL/STATUS bit positions.
- One sub-module, glitch_trig_sync: synchronizer plus edge detector, parameterised by SYNC_STAGES and polarity, outputting trig_edge.
- Bus register file and FSM stay in glitch_sequencer.

Test Plan:
- Reset check: after reset, read STATUS -> 0, glitch_out=0, and a read of offset 7 returns 0 with iomem_ready high exactly 1 cycle after valid.
- Basic sequence:
  - Stimulus: DELAY=10, WIDTH=3, PULSES=1, TRIG_RISE=1, ARM, then raise trigger_in.
  - Response: glitch_out high 3 cycles starting 14 cycles after the sampling edge, then done_irq pulses once and STATUS.DONE=1.
- Pulse train:
  - Stimulus: WIDTH=2, GAP=5, PULSES=3, OUT_POL=1, DELAY=0.
  - Response: glitch_out low for 2 cycles, high for 5, repeated, for 3 pulses total; STATUS[23:16]=3.
- Zero values: WIDTH=0, GAP=0, PULSES=0 -> a single 1-cycle pulse.
- Boundary events:
  - Falling-edge trigger with TRIG_RISE=0 arms correctly; a rising edge does not fire.
  - Retrigger during DELAY is ignored.
  - Writing DELAY while ARMED leaves the register unchanged.
- Abort and reset:
  - ABORT written mid-PULSE -> glitch_out idle next cycle, ABORTED=1, no done_irq.
  - ARM+ABORT in one write stays IDLE.
  - resetn low mid-GAP -> all outputs and registers 0.
